// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// CTRL_ILLEGAL_TRAP_EN adds the TRAP state used for illegal opcodes.
package ctrl_pkg;

`ifdef CTRL_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB
    } state_t;
`endif

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_L     = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_L, OP_S, OP_B,
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// Combinational ALU-operation decode from opcode/funct3/funct7.
module ctrl_alu_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op
);

    logic [3:0] base_op;
    logic       unused_funct7;

    // Only bit 5 of funct7 selects between operation variants.
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    always_comb begin
        case (funct3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_R: begin
                if (funct7[5] && funct3 == 3'b000)
                    alu_op = ALU_SUB;
                else if (funct7[5] && funct3 == 3'b101)
                    alu_op = ALU_SRA;
                else
                    alu_op = base_op;
            end
            OP_I: begin
                // No SUBI: only the shift-right form honours funct7[5].
                if (funct7[5] && funct3 == 3'b101)
                    alu_op = ALU_SRA;
                else
                    alu_op = base_op;
            end
            OP_LUI:  alu_op = ALU_PASSB;
            OP_B:    alu_op = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with retired-instruction count.
// Define CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes instead of treating them as NOPs.
module multi_cycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 alu_zero,
    input  logic                 alu_lt,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 ir_write,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic                 alu_src_b,
    output logic [3:0]           alu_op,
    output logic [1:0]           wb_sel,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    state_t               state_reg, state_next;
    logic [6:0]           opcode_reg;
    logic [2:0]           funct3_reg;
    logic [6:0]           funct7_reg;
    logic [INSTRET_W-1:0] instret_reg;
    logic [3:0]           dec_alu_op;
    logic                 retire;
    logic                 branch_taken;
    logic                 uses_imm;
    logic                 is_jump;

    ctrl_alu_dec u_alu_dec (
        .opcode (opcode_reg),
        .funct3 (funct3_reg),
        .funct7 (funct7_reg),
        .alu_op (dec_alu_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            opcode_reg  <= '0;
            funct3_reg  <= '0;
            funct7_reg  <= '0;
            instret_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_DECODE) begin
                opcode_reg <= opcode;
                funct3_reg <= funct3;
                funct7_reg <= funct7;
            end
            if (retire)
                instret_reg <= instret_reg + INSTRET_W'(1);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_reg <= 1'b0;
        else if (state_reg == ST_DECODE && !is_legal_op(opcode))
            illegal_reg <= 1'b1;
    end

    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    assign instret = instret_reg;

    always_comb begin
        case (funct3_reg)
            3'b000:         branch_taken = alu_zero;
            3'b001:         branch_taken = !alu_zero;
            3'b100, 3'b110: branch_taken = alu_lt;
            3'b101, 3'b111: branch_taken = !alu_lt;
            default:        branch_taken = 1'b0;
        endcase
    end

    assign is_jump  = (opcode_reg == OP_JAL) || (opcode_reg == OP_JALR);
    assign uses_imm = (opcode_reg == OP_I) || (opcode_reg == OP_L) || (opcode_reg == OP_S) ||
                      (opcode_reg == OP_LUI) || (opcode_reg == OP_AUIPC) || is_jump;

    always_comb begin
        state_next = state_reg;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        pc_src     = PC_SRC_PLUS4;
        reg_write  = 1'b0;
        alu_src_b  = 1'b0;
        alu_op     = ALU_ADD;
        wb_sel     = WB_ALU;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            ST_IDLE: state_next = ST_FETCH;
            ST_FETCH: begin
                pc_write   = 1'b1;
                ir_write   = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                // Legality is judged on the live decoder output being latched this cycle.
                if (is_legal_op(opcode)) begin
                    state_next = ST_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_next = ST_TRAP;
`else
                    state_next = ST_FETCH;
                    retire     = 1'b1;
`endif
                end
            end
            ST_EXEC: begin
                alu_op    = dec_alu_op;
                alu_src_b = uses_imm;
                case (opcode_reg)
                    OP_L, OP_S: state_next = ST_MEM;
                    OP_B: begin
                        pc_write   = branch_taken;
                        pc_src     = branch_taken ? PC_SRC_BRANCH : PC_SRC_PLUS4;
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                    default: state_next = ST_WB;
                endcase
            end
            ST_MEM: begin
                mem_read  = (opcode_reg == OP_L);
                mem_write = (opcode_reg != OP_L);
                if (mem_ready) begin
                    if (opcode_reg == OP_L) begin
                        state_next = ST_WB;
                    end else begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                wb_sel     = (opcode_reg == OP_L) ? WB_MEM : (is_jump ? WB_PC4 : WB_ALU);
                pc_write   = is_jump;
                pc_src     = is_jump ? PC_SRC_JUMP : PC_SRC_PLUS4;
                state_next = ST_FETCH;
                retire     = 1'b1;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: state_next = ST_TRAP;
`endif
            default: state_next = ST_IDLE;
        endcase
    end

endmodule
